// File: rtl/sm_pkg.sv
// Shared definitions for the bit-serial adder family: state encodings and default width.
package sm_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COLLECT = 2'd1;
   localparam logic [1:0] ST_DONE    = 2'd2;

   localparam int SM_W = 8;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      COLLECT = ST_COLLECT,
      DONE    = ST_DONE
   } sm_state_e;

endpackage : sm_pkg

// File: rtl/serial_shift_in.sv
// W-bit right-shift register: new bits enter at the MSB, so the first bit lands in bit 0 after W shifts.
module serial_shift_in #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         clear_i,
   input  logic         shift_i,
   input  logic         bit_i,
   output logic [W-1:0] data_o
);

   logic [W-1:0] data_q;
   logic [W-1:0] data_d;

   // Clear wins over shift so an abort or restart discards a coincident bit.
   always_comb begin
      data_d = data_q;
      if (clear_i) begin
         data_d = '0;
      end else if (shift_i) begin
         data_d = {bit_i, data_q[W-1:1]};
      end
   end

   always_ff @(posedge clk_i) begin
      data_q <= data_d;
   end

   assign data_o = data_q;

endmodule : serial_shift_in

// File: rtl/serial_sum_deser.sv
// Collects W LSB-first sum bits and the final carry from the serial adder,
// then holds the parallel result on a valid/ready handshake.
module serial_sum_deser
   import sm_pkg::*;
#(
   parameter int W  = SM_W,
   parameter int CW = $clog2(W)
) (
   input  logic         CLK,
   input  logic         NRST,
   input  logic         rst,
   input  logic         start,
   input  logic         bit_valid,
   input  logic         S,
   input  logic         COUT,
   input  logic         sum_ready,
   output logic [W-1:0] sum,
   output logic         cout_q,
   output logic         sum_valid,
   output logic         busy,
   output logic         overrun
);

   // Handshake: a result is transferred on any edge where sum_valid and sum_ready are both high.

   sm_state_e     state_q;
   logic [CW-1:0] cnt_q;
   logic          cout_qq;
   logic          sum_valid_q;
   logic          busy_q;
   logic          overrun_q;

   logic          start_taken;
   logic          clear_sum;
   logic          shift_sum;

   // A start is ignored only while a result is held and not being accepted.
   always_comb begin
      start_taken = 1'b0;
      if (start) begin
         start_taken = (state_q != DONE) || sum_ready;
      end
   end

   assign clear_sum = !NRST || rst || start_taken;
   assign shift_sum = (state_q == COLLECT) && bit_valid && !start;

   serial_shift_in #(.W(W)) u_shift (
      .clk_i   (CLK),
      .clear_i (clear_sum),
      .shift_i (shift_sum),
      .bit_i   (S),
      .data_o  (sum)
   );

   always_ff @(posedge CLK) begin
      if (!NRST || rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         cout_qq     <= 1'b0;
         sum_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= COLLECT;
                  cnt_q   <= '0;
                  cout_qq <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            COLLECT: begin
               if (start) begin
                  cnt_q   <= '0;
                  cout_qq <= 1'b0;
               end else if (bit_valid) begin
                  cnt_q <= cnt_q + CW'(1);
                  if (cnt_q == CW'(W - 1)) begin
                     cout_qq     <= COUT;
                     state_q     <= DONE;
                     busy_q      <= 1'b0;
                     sum_valid_q <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (sum_ready) begin
                  sum_valid_q <= 1'b0;
                  if (start) begin
                     state_q <= COLLECT;
                     cnt_q   <= '0;
                     cout_qq <= 1'b0;
                     busy_q  <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                  end
               end else if (start) begin
                  overrun_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               busy_q      <= 1'b0;
               sum_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign cout_q    = cout_qq;
   assign sum_valid = sum_valid_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule : serial_sum_deser

// File: tb/tb_serial_sum_deser.sv
// Directed bench for serial_sum_deser at W=8 with hand-computed results.
module tb_serial_sum_deser;

   logic       CLK;
   logic       NRST;
   logic       rst;
   logic       start;
   logic       bit_valid;
   logic       S;
   logic       COUT;
   logic       sum_ready;
   logic [7:0] sum;
   logic       cout_q;
   logic       sum_valid;
   logic       busy;
   logic       overrun;

   int n_checks = 0;
   int n_errors = 0;

   serial_sum_deser #(.W(8)) dut (
      .CLK       (CLK),
      .NRST      (NRST),
      .rst       (rst),
      .start     (start),
      .bit_valid (bit_valid),
      .S         (S),
      .COUT      (COUT),
      .sum_ready (sum_ready),
      .sum       (sum),
      .cout_q    (cout_q),
      .sum_valid (sum_valid),
      .busy      (busy),
      .overrun   (overrun)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Feed 8 bits LSB first; the final carry rides on the last bit. Gaps insert an idle cycle before each bit.
   task automatic send_bits(input logic [7:0] v, input logic c, input bit gaps);
      for (int i = 0; i < 8; i++) begin
         if (gaps) begin
            bit_valid = 1'b0;
            step();
            if (busy !== 1'b1) begin
               $display("FAIL gap_busy bit %0d: got %b want 1", i, busy);
               n_errors++;
            end
            n_checks++;
         end
         bit_valid = 1'b1;
         S         = v[i];
         COUT      = (i == 7) ? c : 1'b0;
         step();
         if (gaps && i < 7) begin
            if (busy !== 1'b1) begin
               $display("FAIL gap_busy_bit %0d: got %b want 1", i, busy);
               n_errors++;
            end
            n_checks++;
         end
      end
      bit_valid = 1'b0;
      S         = 1'b0;
      COUT      = 1'b0;
   endtask

   task automatic check_result(input string name, input logic [7:0] exp_sum, input logic exp_c);
      if (sum_valid !== 1'b1 || busy !== 1'b0) begin
         $display("FAIL %s_flags: valid=%b busy=%b want valid=1 busy=0", name, sum_valid, busy);
         n_errors++;
      end
      n_checks++;
      if (sum !== exp_sum || cout_q !== exp_c) begin
         $display("FAIL %s_data: sum=%h cout=%b want sum=%h cout=%b", name, sum, cout_q, exp_sum, exp_c);
         n_errors++;
      end
      n_checks++;
   endtask

   task automatic accept();
      sum_ready = 1'b1;
      step();
      sum_ready = 1'b0;
      if (sum_valid !== 1'b0) begin
         $display("FAIL accept_valid: got %b want 0", sum_valid);
         n_errors++;
      end
      n_checks++;
   endtask

   task automatic test_reset();
      NRST = 1'b0;
      step();
      step();
      NRST = 1'b1;
      if ({sum, cout_q, sum_valid, busy, overrun} !== 12'h000) begin
         $display("FAIL reset: sum=%h c=%b v=%b b=%b o=%b want all 0", sum, cout_q, sum_valid, busy, overrun);
         n_errors++;
      end
      n_checks++;
   endtask

   task automatic test_basic();
      pulse_start();
      if (busy !== 1'b1) begin
         $display("FAIL basic_busy: got %b want 1", busy);
         n_errors++;
      end
      n_checks++;
      send_bits(8'h96, 1'b0, 1'b0);
      check_result("basic", 8'h96, 1'b0);
      accept();
      if (sum !== 8'h96) begin
         $display("FAIL basic_hold_after_accept: sum=%h want 96", sum);
         n_errors++;
      end
      n_checks++;
   endtask

   task automatic test_idle_ignore();
      for (int i = 0; i < 3; i++) begin
         bit_valid = 1'b1;
         S         = 1'b1;
         step();
      end
      bit_valid = 1'b0;
      if (busy !== 1'b0 || sum_valid !== 1'b0 || sum !== 8'h96) begin
         $display("FAIL idle_ignore: busy=%b valid=%b sum=%h want 0 0 96", busy, sum_valid, sum);
         n_errors++;
      end
      n_checks++;
   endtask

   task automatic test_hold();
      pulse_start();
      send_bits(8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
         check_result("hold", 8'h00, 1'b1);
      end
      accept();
   endtask

   task automatic test_gaps();
      pulse_start();
      send_bits(8'h96, 1'b0, 1'b1);
      check_result("gaps", 8'h96, 1'b0);
      accept();
   endtask

   task automatic test_overrun();
      pulse_start();
      send_bits(8'h96, 1'b0, 1'b0);
      pulse_start();
      if (overrun !== 1'b1) begin
         $display("FAIL overrun_set: got %b want 1", overrun);
         n_errors++;
      end
      n_checks++;
      check_result("overrun_held", 8'h96, 1'b0);
      start     = 1'b1;
      sum_ready = 1'b1;
      step();
      start     = 1'b0;
      sum_ready = 1'b0;
      if (busy !== 1'b1 || sum_valid !== 1'b0 || overrun !== 1'b1 || sum !== 8'h00) begin
         $display("FAIL b2b_restart: busy=%b valid=%b ovr=%b sum=%h want 1 0 1 00", busy, sum_valid, overrun, sum);
         n_errors++;
      end
      n_checks++;
      send_bits(8'hA5, 1'b1, 1'b0);
      check_result("b2b_frame", 8'hA5, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      if (overrun !== 1'b0 || sum !== 8'h00 || sum_valid !== 1'b0 || cout_q !== 1'b0) begin
         $display("FAIL rst_clear: ovr=%b sum=%h valid=%b c=%b want 0 00 0 0", overrun, sum, sum_valid, cout_q);
         n_errors++;
      end
      n_checks++;
   endtask

   task automatic test_abort();
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         bit_valid = 1'b1;
         S         = 1'b1;
         step();
      end
      bit_valid = 1'b0;
      rst       = 1'b1;
      step();
      rst       = 1'b0;
      if (busy !== 1'b0 || sum !== 8'h00) begin
         $display("FAIL abort: busy=%b sum=%h want 0 00", busy, sum);
         n_errors++;
      end
      n_checks++;
      pulse_start();
      send_bits(8'h96, 1'b0, 1'b0);
      check_result("after_abort", 8'h96, 1'b0);
      accept();
   endtask

   task automatic test_restart();
      pulse_start();
      for (int i = 0; i < 3; i++) begin
         bit_valid = 1'b1;
         S         = 1'b1;
         step();
      end
      start     = 1'b1;
      bit_valid = 1'b1;
      S         = 1'b1;
      step();
      start     = 1'b0;
      bit_valid = 1'b0;
      if (busy !== 1'b1 || sum !== 8'h00) begin
         $display("FAIL restart: busy=%b sum=%h want 1 00", busy, sum);
         n_errors++;
      end
      n_checks++;
      send_bits(8'h96, 1'b0, 1'b0);
      check_result("after_restart", 8'h96, 1'b0);
      NRST = 1'b0;
      step();
      NRST = 1'b1;
      if ({sum, cout_q, sum_valid, busy, overrun} !== 12'h000) begin
         $display("FAIL nrst_in_done: sum=%h c=%b v=%b b=%b o=%b want all 0", sum, cout_q, sum_valid, busy, overrun);
         n_errors++;
      end
      n_checks++;
   endtask

   initial begin
      NRST      = 1'b0;
      rst       = 1'b0;
      start     = 1'b0;
      bit_valid = 1'b0;
      S         = 1'b0;
      COUT      = 1'b0;
      sum_ready = 1'b0;
      test_reset();
      test_basic();
      test_idle_ignore();
      test_hold();
      test_gaps();
      test_overrun();
      test_abort();
      test_restart();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_serial_sum_deser
